// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants and the fetch-queue entry layout.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus_4;
    logic [XLEN-1:0] instr;
    logic            filled;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_unit_if.sv
// Instruction-memory request/response and decode handshake bundle of the fetch stage.
interface ifetch_unit_if;
  import cpu_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_instr;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_pc_plus_4;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    output id_valid, id_instr, id_pc, id_pc_plus_4,
    input  id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    input  id_valid, id_instr, id_pc, id_pc_plus_4,
    output id_ready
  );

endinterface

// File: rtl/ifetch_unit_queue.sv
// In-order fetch buffer: entries are allocated at request time and filled by responses
// in request order; head/tail/fill pointers carry an extra wrap bit.
module ifetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            push,
  input  logic [XLEN-1:0] push_pc,
  input  logic [XLEN-1:0] push_pc_plus_4,
  input  logic            fill,
  input  logic [XLEN-1:0] fill_data,
  input  logic            pop,
  output fetch_entry_t    head,
  output logic [CW-1:0]   occupancy,
  output logic [CW-1:0]   unfilled
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t entries [DEPTH];
  logic [AW:0]  head_ptr;
  logic [AW:0]  tail_ptr;
  logic [AW:0]  fill_ptr;

  // Push, fill and pop never target the same slot: fill only touches allocated
  // unfilled entries, pop only the filled head, push only a free slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      fill_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      fill_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i].filled <= 1'b0;
      end
    end else begin
      if (push) begin
        entries[tail_ptr[AW-1:0]] <= '{pc: push_pc, pc_plus_4: push_pc_plus_4,
                                       instr: '0, filled: 1'b0};
        tail_ptr <= tail_ptr + 1'b1;
      end
      if (fill) begin
        entries[fill_ptr[AW-1:0]].instr  <= fill_data;
        entries[fill_ptr[AW-1:0]].filled <= 1'b1;
        fill_ptr <= fill_ptr + 1'b1;
      end
      if (pop) begin
        entries[head_ptr[AW-1:0]].filled <= 1'b0;
        head_ptr <= head_ptr + 1'b1;
      end
    end
  end

  assign head      = entries[head_ptr[AW-1:0]];
  assign occupancy = CW'(tail_ptr - head_ptr);
  assign unfilled  = CW'(tail_ptr - fill_ptr);

endmodule

// File: rtl/ifetch_unit.sv
// Fetch stage: issues one read per PC, buffers responses in order for decode and
// discards responses that belong to fetches flushed by a branch.
module ifetch_unit
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] pc_plus_4,
  input  logic            branch,
  output logic            pc_en,
  ifetch_unit_if.master   bus
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t  head;
  logic [CW-1:0] occupancy;
  logic [CW-1:0] unfilled;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] drop_nxt;
  logic [CW:0]   in_flight;
  logic          req_fire;
  logic          rsp_drop;
  logic          rsp_fill;
  logic          id_fire;
  logic          unused_pc_bits;

  assign unused_pc_bits = ^pc[1:0];

  // Credits cover both buffered entries and responses still owed to flushed fetches.
  assign in_flight          = {1'b0, occupancy} + {1'b0, drop_cnt};
  assign bus.imem_req_valid = rst && !branch && (in_flight < (CW + 1)'(DEPTH));
  assign bus.imem_req_addr  = {pc[XLEN-1:2], 2'b00};
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;
  assign pc_en              = req_fire || branch;

  assign rsp_drop = bus.imem_rsp_valid && (drop_cnt != '0);
  assign rsp_fill = bus.imem_rsp_valid && !branch && (drop_cnt == '0) && (unfilled != '0);

  assign bus.id_valid     = head.filled && !branch;
  assign bus.id_instr     = head.instr;
  assign bus.id_pc        = head.pc;
  assign bus.id_pc_plus_4 = head.pc_plus_4;
  assign id_fire          = bus.id_valid && bus.id_ready;

  ifetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk            (clk),
    .rst            (rst),
    .flush          (branch),
    .push           (req_fire),
    .push_pc        (pc),
    .push_pc_plus_4 (pc_plus_4),
    .fill           (rsp_fill),
    .fill_data      (bus.imem_rsp_data),
    .pop            (id_fire),
    .head           (head),
    .occupancy      (occupancy),
    .unfilled       (unfilled)
  );

  // On a flush every unfilled entry becomes a response to discard; a response
  // arriving in the flush cycle retires one of the outstanding requests itself.
  always_comb begin
    drop_nxt = drop_cnt;
    if (branch) begin
      drop_nxt = drop_cnt + unfilled - CW'(bus.imem_rsp_valid);
    end else if (rsp_drop) begin
      drop_nxt = drop_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt <= '0;
    end else begin
      drop_cnt <= drop_nxt;
    end
  end

  rsp_has_owner: assert property (@(posedge clk) disable iff (!rst)
    bus.imem_rsp_valid |-> (drop_cnt != '0) || (unfilled != '0))
    else $error("ifetch_unit: response with no outstanding request");

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: a small PC model and in-order memory model drive
// the DUT; expected decode words are queued by the stimulus and checked by a monitor.
module tb_ifetch_unit;
  import cpu_pkg::*;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
    logic [31:0] instr;
  } expect_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_req_t;

  logic        clk;
  logic        rst;
  logic        branch;
  logic        pc_en;
  logic [31:0] pc_reg;
  logic [31:0] pc_plus_4;
  logic [31:0] branch_addr;

  int       compared   = 0;
  int       mismatched = 0;
  int       cyc        = 0;
  int       lat        = 1;
  bit       ready_en   = 0;
  expect_t  sb[$];
  mem_req_t pend[$];

  ifetch_unit_if bus();

  ifetch_unit #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .pc        (pc_reg),
    .pc_plus_4 (pc_plus_4),
    .branch    (branch),
    .pc_en     (pc_en),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign pc_plus_4 = pc_reg + 32'd4;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return {8'hE5, addr[25:2]};
  endfunction

  // PC stage model: loads the branch target, otherwise advances only on pc_en.
  always @(posedge clk or negedge rst) begin
    if (!rst)        pc_reg <= 32'h0;
    else if (branch) pc_reg <= branch_addr;
    else if (pc_en)  pc_reg <= pc_reg + 32'd4;
  end

  // Memory and decode-ready model, evaluated once per cycle after the stimulus settles.
  always @(negedge clk) begin
    #1;
    cyc++;
    if (!rst) begin
      pend.delete();
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'h0;
      bus.id_ready       = 1'b0;
    end else begin
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = mem_word(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        bus.imem_rsp_valid = 1'b0;
      end
      bus.id_ready = ready_en && (sb.size() > 0);
      if (bus.imem_req_valid && bus.imem_req_ready)
        pend.push_back('{addr: bus.imem_req_addr, due: cyc + lat});
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: every decode handshake pops one expected instruction.
  always @(negedge clk) begin
    #2;
    if (rst === 1'b1 && bus.id_valid === 1'b1 && bus.id_ready === 1'b1) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_id: got id_pc 0x%08h, expected no instruction", bus.id_pc);
      end else begin
        expect_t e;
        e = sb.pop_front();
        checkOutput("id_pc", bus.id_pc, e.pc);
        checkOutput("id_pc_plus_4", bus.id_pc_plus_4, e.pc_plus_4);
        checkOutput("id_instr", bus.id_instr, e.instr);
      end
    end
  end

  task automatic applyStimulus(input logic br, input logic [31:0] target, input logic mem_rdy);
    branch             = br;
    branch_addr        = target;
    bus.imem_req_ready = mem_rdy;
  endtask

  task automatic pushExpected(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      a = start + 32'(4 * i);
      sb.push_back('{pc: a, pc_plus_4: a + 32'd4, instr: mem_word(a)});
    end
  endtask

  task automatic waitDrain(input string name, input int max_cycles);
    int n;
    n = 0;
    while (sb.size() > 0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (sb.size() > 0) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d instructions left, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b1);

    // Reset values
    repeat (2) @(negedge clk);
    #2;
    checkOutput("rst_id_valid", 32'(bus.id_valid), 32'h0);
    checkOutput("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
    checkOutput("rst_id_instr", bus.id_instr, 32'h0);
    checkOutput("rst_id_pc", bus.id_pc, 32'h0);
    checkOutput("rst_id_pc_plus_4", bus.id_pc_plus_4, 32'h0);

    // Streaming from pc 0 with a 1-cycle memory
    @(negedge clk);
    rst      = 1'b1;
    ready_en = 1'b1;
    pushExpected(32'h0, 8);
    waitDrain("drain_stream", 60);
    repeat (6) @(negedge clk);

    // Decode stalled: queue full with 0x20..0x2C, PC held at 0x30
    #2;
    checkOutput("full_req_valid", 32'(bus.imem_req_valid), 32'h0);
    checkOutput("full_pc_en", 32'(pc_en), 32'h0);
    checkOutput("full_pc_held", pc_reg, 32'h30);
    checkOutput("full_head_pc", bus.id_pc, 32'h20);
    @(negedge clk);
    pushExpected(32'h20, 8);
    #2;
    checkOutput("pop_cycle_req_valid", 32'(bus.imem_req_valid), 32'h0);
    @(negedge clk);
    #2;
    checkOutput("resume_req_valid", 32'(bus.imem_req_valid), 32'h1);
    checkOutput("resume_pc_en", 32'(pc_en), 32'h1);
    waitDrain("drain_resume", 60);
    repeat (6) @(negedge clk);

    // Memory not ready for 3 cycles: PC held at 0x50
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b0);
    pushExpected(32'h40, 12);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #2;
      checkOutput("stall_pc_en", 32'(pc_en), 32'h0);
      checkOutput("stall_pc_held", pc_reg, 32'h50);
    end
    checkOutput("stall_req_valid", 32'(bus.imem_req_valid), 32'h1);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b1);
    waitDrain("drain_stall", 60);
    repeat (8) @(negedge clk);

    // Redirect with two fetches outstanding (memory answers 3 cycles after accept)
    @(negedge clk);
    lat = 3;
    applyStimulus(1'b1, 32'h80, 1'b1);
    #2;
    checkOutput("flush_id_valid", 32'(bus.id_valid), 32'h0);
    checkOutput("flush_req_valid", 32'(bus.imem_req_valid), 32'h0);
    checkOutput("flush_pc_en", 32'(pc_en), 32'h1);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    applyStimulus(1'b1, 32'h100, 1'b1);
    pushExpected(32'h100, 6);
    #2;
    checkOutput("redirect_unfilled", 32'(dut.unfilled), 32'h2);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b1);
    #2;
    checkOutput("redirect_drop_cnt", 32'(dut.drop_cnt), 32'h2);
    checkOutput("redirect_occupancy", 32'(dut.occupancy), 32'h0);
    waitDrain("drain_redirect", 80);
    repeat (10) @(negedge clk);

    // Branch coinciding with a response and a ready decode (2-cycle memory)
    @(negedge clk);
    lat = 2;
    applyStimulus(1'b1, 32'h180, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    applyStimulus(1'b1, 32'h200, 1'b1);
    pushExpected(32'h200, 6);
    #2;
    checkOutput("coinc_id_valid", 32'(bus.id_valid), 32'h0);
    checkOutput("coinc_unfilled", 32'(dut.unfilled), 32'h2);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b1);
    #2;
    checkOutput("coinc_drop_cnt", 32'(dut.drop_cnt), 32'h1);
    checkOutput("coinc_occupancy", 32'(dut.occupancy), 32'h0);
    waitDrain("drain_coinc", 60);
    repeat (8) @(negedge clk);

    // Reset with three entries queued, then restart from pc 0
    @(negedge clk);
    pushExpected(32'h218, 1);
    @(negedge clk);
    checkOutput("pre_reset_occupancy", 32'(dut.occupancy), 32'h3);
    rst = 1'b0;
    #2;
    checkOutput("midrst_id_valid", 32'(bus.id_valid), 32'h0);
    checkOutput("midrst_req_valid", 32'(bus.imem_req_valid), 32'h0);
    checkOutput("midrst_occupancy", 32'(dut.occupancy), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    pushExpected(32'h0, 4);
    waitDrain("drain_restart", 40);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    mismatched++;
    $display("[TB] FAIL watchdog: got no completion, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
